// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: one shift-and-add iteration per clock,
// fixed latency of WIDTH cycles after the accepting edge.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active low
//   start     request to begin a multiplication
//   valid_in  qualifies a/b; start accepted only with start & valid_in
//   a, b      unsigned multiplicand / multiplier (WIDTH bits)
//   product   registered result a*b (2*WIDTH bits), held until next result
//   valid_out one-cycle pulse, product is valid
//   done      one-cycle pulse, coincident with valid_out
module shift_add_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 valid_out,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               busy;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;

    logic               accept;
    logic               last;
    logic [2*WIDTH-1:0] sum;

    always_comb begin
        accept = (state == IDLE) && start && valid_in;
        last   = (state == RUN) && (count == CW'(WIDTH - 1));
        // Sum for the current iteration; also the final product on the last one.
        sum    = acc + (mplier[0] ? mcand : '0);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (last)   state_next = IDLE;
            default:          state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            product   <= '0;
            valid_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            if (accept) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                count  <= '0;
                busy   <= 1'b1;
            end else if (state == RUN) begin
                // No early exit: always WIDTH iterations for fixed latency.
                acc    <= sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
                if (last) begin
                    product   <= sum;
                    done      <= 1'b1;
                    valid_out <= 1'b1;
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult: latency, pulse width, hold behaviour,
// ignored starts, reset abort, back-to-back and random operands.
module tb_shift_add_mult;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          valid_in = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [2*W-1:0] product;
    logic          valid_out;
    logic          done;

    int checks = 0;
    int fails  = 0;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .valid_in (valid_in),
        .a        (a),
        .b        (b),
        .product  (product),
        .valid_out(valid_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands for one edge; returns #1 after that edge.
    task automatic launch(input logic [W-1:0] aa, input logic [W-1:0] bb);
        a = aa;
        b = bb;
        start = 1'b1;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        valid_in = 1'b0;
        check("busy_after_accept", 64'(dut.busy), 64'd1);
    endtask

    // Wait for done; product must hold prev until then. Returns in done cycle.
    task automatic wait_done(input string tag, input logic [2*W-1:0] exp,
                             input logic [2*W-1:0] prev);
        int n;
        n = 0;
        for (int i = 1; i <= W + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
            check({tag, "_hold"}, 64'(product), 64'(prev));
        end
        check({tag, "_latency"}, 64'(n), 64'(W));
        check({tag, "_product"}, 64'(product), 64'(exp));
        check({tag, "_valid"}, 64'(valid_out), 64'd1);
        check({tag, "_busy"}, 64'(dut.busy), 64'd0);
    endtask

    // One cycle after done: pulses gone, product held.
    task automatic pulse_end(input string tag, input logic [2*W-1:0] exp);
        @(posedge clk);
        #1;
        check({tag, "_done_low"}, 64'(done), 64'd0);
        check({tag, "_valid_low"}, 64'(valid_out), 64'd0);
        check({tag, "_held"}, 64'(product), 64'(exp));
    endtask

    initial begin
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [2*W-1:0] rexp;
        logic [2*W-1:0] last_p;
        int             seen;

        // Reset state
        #12;
        check("rst_product", 64'(product), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_busy", 64'(dut.busy), 64'd0);
        check("rst_count", 64'(dut.count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy", 64'(dut.busy), 64'd0);
        check("post_rst_count", 64'(dut.count), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);

        // Unqualified starts are ignored
        start = 1'b1;
        a = 16'd9;
        b = 16'd9;
        @(posedge clk);
        #1;
        check("start_no_valid", 64'(dut.busy), 64'd0);
        start = 1'b0;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        check("valid_no_start", 64'(dut.busy), 64'd0);
        valid_in = 1'b0;

        // Zero operands
        launch(16'd0, 16'd0);
        wait_done("zero", 32'd0, 32'd0);
        pulse_end("zero", 32'd0);

        // Directed products
        launch(16'hFFFF, 16'hFFFF);
        wait_done("max", 32'hFFFE0001, 32'd0);
        pulse_end("max", 32'hFFFE0001);
        launch(16'd123, 16'd456);
        wait_done("p123", 32'd56088, 32'hFFFE0001);
        pulse_end("p123", 32'd56088);
        launch(16'd32768, 16'd2);
        wait_done("p32768", 32'd65536, 32'd56088);
        pulse_end("p32768", 32'd65536);
        launch(16'd1, 16'hFFFF);
        wait_done("p1", 32'd65535, 32'd65536);
        pulse_end("p1", 32'd65535);

        // Start re-asserted mid-run is ignored
        launch(16'd7, 16'd11);
        repeat (4) @(posedge clk);
        #1;
        a = 16'd3;
        b = 16'd4;
        start = 1'b1;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        valid_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen++;
                check("midrun_product", 64'(product), 64'd77);
            end
        end
        check("midrun_pulses", 64'(seen), 64'd1);
        check("midrun_held", 64'(product), 64'd77);

        // Reset mid-run aborts without a pulse
        launch(16'd10, 16'd10);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("abort_product", 64'(product), 64'd0);
        check("abort_busy", 64'(dut.busy), 64'd0);
        check("abort_count", 64'(dut.count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            if (done || valid_out) seen++;
        end
        check("abort_no_pulse", 64'(seen), 64'd0);
        launch(16'd256, 16'd256);
        wait_done("p256", 32'd65536, 32'd0);
        pulse_end("p256", 32'd65536);

        // Back-to-back: restart in the done cycle
        launch(16'd300, 16'd3);
        wait_done("b2b_first", 32'd900, 32'd65536);
        launch(16'd5678, 16'd1);
        check("b2b_done_low", 64'(done), 64'd0);
        wait_done("b2b_second", 32'd5678, 32'd900);
        pulse_end("b2b_second", 32'd5678);

        // Random operands
        last_p = 32'd5678;
        for (int k = 0; k < 12; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rexp = 32'(ra) * 32'(rb);
            launch(ra, rb);
            wait_done("rand", rexp, last_p);
            pulse_end("rand", rexp);
            last_p = rexp;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter: WIDTH, default 16, operand width in bits (legal: >= 2).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-005 Port: start  input  1  request to begin a multiplication.
REQ-006 Port: valid_in  input  1  qualifies a/b; a start is accepted only when start and valid_in are both 1.
REQ-007 Port: a  input  WIDTH  unsigned multiplicand.
REQ-008 Port: b  input  WIDTH  unsigned multiplier.
REQ-009 Port: product  output  2*WIDTH  registered unsigned result a*b.
REQ-010 Port: valid_out  output  1  one-cycle pulse; product is valid.
REQ-011 Port: done  output  1  one-cycle pulse; operation complete, coincident with valid_out.
REQ-012 Internal registers named busy (1 bit, operation in progress) and count (iteration counter, $clog2(WIDTH)+1 bits) SHALL exist under those names for hierarchical probing by the bench.

Function
REQ-013 Two states: IDLE (busy=0) and RUN (busy=1).
REQ-014 IDLE -> RUN at a rising edge where start=1 and valid_in=1: capture a into a 2*WIDTH-bit multiplicand register (zero-extended), capture b into a WIDTH-bit multiplier register, clear the accumulator, set count=0, set busy=1.
REQ-015 Start with valid_in=0, or valid_in with start=0, SHALL be ignored.
REQ-016 In RUN, each edge performs one iteration: if multiplier LSB=1, accumulator += multiplicand; then multiplicand shifts left 1, multiplier shifts right 1, count increments.
REQ-017 RUN SHALL perform exactly WIDTH iterations, with no early exit on a zero multiplier; latency is fixed regardless of operand values.
REQ-018 On the edge completing iteration WIDTH (the WIDTH-th edge after the accepting edge), the final sum SHALL be loaded into product, done=1, valid_out=1, busy=0 (-> IDLE).
REQ-019 done and valid_out SHALL be high for exactly one cycle, then return to 0.
REQ-020 product SHALL hold its value after completion until the next completed operation or reset; it SHALL NOT change during RUN.
REQ-021 start/valid_in asserted while busy=1 SHALL be ignored; the operation in progress is unaffected and a/b changes during RUN have no effect.
REQ-022 start and valid_in asserted in the cycle where done=1 (state already IDLE) SHALL be accepted as a new operation.
REQ-023 Arithmetic is unsigned, with a 2*WIDTH-bit accumulator; the full product is always representable, so no overflow or truncation occurs.
REQ-024 Throughput: one result per WIDTH+1 cycles minimum (accept edge plus WIDTH iterations).

Reset
REQ-025 While rst=0, asynchronously: product=0, valid_out=0, done=0, busy=0, count=0, accumulator and operand registers=0, state=IDLE.
REQ-026 Reset asserted mid-operation SHALL abort it, with no done/valid_out pulse; after release the block is IDLE and accepts a new start.
REQ-027 After reset release, done=0, valid_out=0, busy=0 and count=0 until a start is accepted.

Verification
REQ-028 a=0, b=0, start+valid_in one cycle -> done pulses WIDTH cycles after acceptance; product=0, held afterwards.
REQ-029 a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001; a=123, b=456 -> 56088; a=32768, b=2 -> 65536; a=1, b=16'hFFFF -> 65535.
REQ-030 Start with a=7, b=11, then re-assert start with a=3, b=4 mid-RUN -> single done pulse, product=77.
REQ-031 Drive rst=0 mid-RUN, release, then start a=256, b=256 -> no pulse from the aborted operation; product=65536 after WIDTH cycles.
REQ-032 Back-to-back: restart in the done cycle with a=5678, b=1 -> second done exactly WIDTH cycles later, product=5678; previous product held until then.
REQ-033 10+ random operand pairs checked against a*b (2*WIDTH bits) -> all match, and each done pulse lasts exactly one cycle.
